alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Front-end stage that feeds the 16-bit `alu` from the 8-bit Tiny Tapeout input pins. It accepts bytes qualified by a manually or externally toggled strobe and assembles them little-endian into operand A, operand B and the opcode. It then drives the ALU's `data_in`, `load_A`, `load_B`, `load_Op` and `updateRes` inputs with single-cycle pulses. One complete frame (A, B, OP) produces exactly one ALU result update.

## Interface
- `N`, 16, ALU operand width; must be a multiple of 8 and ≥ 8. BYTES = N/8 bytes per operand.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `byte_in`  in  8  data byte from input pins; sampled in the same cycle a strobe edge is accepted.
- `strobe`  in  1  asynchronous byte-valid strobe; each rising edge delivers one byte.
- `clear`  in  1  synchronous frame abort, active-high; lower priority than `rst_n`.
- `data_out`  out  N  value presented to ALU `data_in`.
- `load_A`  out  1  one-cycle pulse; ALU captures A.
- `load_B`  out  1  one-cycle pulse; ALU captures B.
- `load_Op`  out  1  one-cycle pulse; ALU captures `data_out[1:0]`.
- `updateRes`  out  1  one-cycle pulse; ALU registers result and flags.
- `phase`  out  2  current frame phase: 0 = A, 1 = B, 2 = OP.
- `busy`  out  1  high when a frame is partially received.

## Operation
- **Strobe path.** `strobe` passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev). This yields `accept`, which is high for one cycle per rising edge. A strobe held high yields exactly one `accept`.
- **Accepted bytes.** On `accept`, `byte_in` is written into byte lane `cnt` of the assembly register `asm`, where `cnt` is in 0..BYTES-1. The first byte is the LSB.
- **Phase A.** After the byte with `cnt` = BYTES-1, in the next cycle: `data_out` ← completed `asm`, `load_A` = 1, `phase` ← B, `cnt` ← 0.
- **Phase B.** Identical to phase A, but pulses `load_B` and then moves to OP.
- **Phase OP.** A single byte. Next cycle: `data_out` ← zero-extended byte, `load_Op` = 1. One cycle after that: `updateRes` = 1. `phase` ← A.
- **Byte lanes.** `asm` lanes not written in the current operand keep stale values, but every lane is overwritten before the load.
- **Holding `data_out`.** `data_out` holds its last loaded value until the next load pulse.
- **Pulse exclusivity.** At most one of `load_A`, `load_B`, `load_Op` is high in any cycle. `updateRes` may coincide with nothing else except a new phase-A byte being accepted.
- **`busy`.** Equals (`phase` != A) | (`cnt` != 0).
- **`clear`.** Sets `phase` ← A and `cnt` ← 0, and cancels any pending load or `updateRes` pulse. An `accept` in the same cycle as `clear` is discarded. `data_out` is unchanged.
- **Reset.** `rst_n` = 0 at any clock edge forces:
  - `phase` = A, `cnt` = 0, `asm` = 0, `data_out` = 0;
  - all pulse outputs = 0, `busy` = 0;
  - synchronizer and edge flops = 0.
- **Reset mid-frame.** The partial frame is lost and no pulse is emitted after reset.

## Timing
- Latency from `strobe` rise to `accept` is 2–3 clocks, due to synchronizer phase.
- Last operand byte `accept` in cycle t → `load_A`/`load_B` and the new `data_out` in cycle t+1.
- OP byte `accept` in cycle t → `load_Op` in t+1 and `updateRes` in t+2. The ALU result is visible at t+3.
- Strobe edges may arrive in consecutive accept-eligible cycles. The loader accepts one byte per cycle with no back-pressure and no dropped bytes, except on `clear` or reset.
- An `accept` coinciding with a registered pulse is processed normally.
- All outputs are registered; there is no combinational path from the inputs.

## Structure
- **Shared package `alu_pkg`:**
  - phase encodings `PH_A` = 2'd0, `PH_B` = 2'd1, `PH_OP` = 2'd2;
  - default width `ALU_N` = 16;
  - `BYTE_W` = 8.
- **Sub-module `strobe_sync`:** 2-flop synchronizer plus rising-edge detector, with output `accept`. The same sub-module is reusable for other pin inputs.
- **Top level:** the `alu_operand_loader` body contains the phase FSM, the byte counter, `asm`, and the output/pulse registers.

## Test plan
- **Basic frame:** after reset, strobe bytes 0x34, 0x12, 0x01, 0x00, 0x02 → `load_A` with `data_out` = 0x1234; `load_B` with 0x0001; `load_Op` with 0x0002; `updateRes` one cycle later. The attached ALU result is 0x1235 with flags 0.
- **Held strobe:** hold `strobe` high for 20 cycles with `byte_in` = 0xAA → exactly one accept, `cnt` = 1, `busy` = 1, no pulses.
- **Reset mid-frame:** send A bytes 0xFF, 0xFF, then one B byte, then drive `rst_n` low for 1 cycle → all outputs 0, `phase` = A. A following full frame 0x05, 0x00, 0x03, 0x00, 0x03 gives `data_out` 0x0005, 0x0003, 0x0003 and ALU result 0x0002.
- **Clear with coincident byte:** assert `clear` in the same cycle as the OP byte `accept` → no `load_Op`, no `updateRes`, `phase` = A, `busy` = 0.
- **Opcode masking:** OP byte 0xFE → `data_out` = 0x00FE and the ALU executes opcode 2 (add).
- **Back-to-back frames:** two full frames with no idle time, with strobes every 4 cycles → two `updateRes` pulses, each preceded by the correct `load_A`, `load_B`, `load_Op` order, with no pulse overlap.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: frame phase encoding and widths.
package alu_pkg;

    localparam int ALU_N  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        PH_A  = 2'd0,
        PH_B  = 2'd1,
        PH_OP = 2'd2
    } phase_e;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer for an asynchronous pin strobe plus a rising-edge
// detector; accept is high for exactly one clock per strobe rise.
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic accept
);

    logic sync1_p0;
    logic sync2_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_p0 <= 1'b0;
            sync2_p1 <= 1'b0;
            prev_p2  <= 1'b0;
        end else begin
            sync1_p0 <= din;
            sync2_p1 <= sync1_p0;
            prev_p2  <= sync2_p1;
        end
    end

    assign accept = sync2_p1 & ~prev_p2;

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles strobed pin bytes little-endian into ALU operands A, B and the
// opcode, and emits the ALU load/update pulses, one result update per frame.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int N = ALU_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   byte_in,
    input  logic         strobe,
    input  logic         clear,
    output logic [N-1:0] data_out,
    output logic         load_A,
    output logic         load_B,
    output logic         load_Op,
    output logic         updateRes,
    output logic [1:0]   phase,
    output logic         busy
);

    localparam int BYTES = N / BYTE_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic accept;

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     asm_q, asm_d, asm_wr;
    logic [N-1:0]     data_q, data_d;
    logic             ld_a_q, ld_a_d;
    logic             ld_b_q, ld_b_d;
    logic             ld_op_q, ld_op_d;
    logic             upd_q, upd_d;

    strobe_sync u_strobe_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (strobe),
        .accept (accept)
    );

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        data_d  = data_q;
        ld_a_d  = 1'b0;
        ld_b_d  = 1'b0;
        ld_op_d = 1'b0;
        upd_d   = ld_op_q;
        asm_wr  = asm_q;
        asm_wr[int'(cnt_q)*BYTE_W +: BYTE_W] = byte_in;

        // clear wins over a coincident byte and kills any queued updateRes
        if (clear) begin
            phase_d = PH_A;
            cnt_d   = '0;
            upd_d   = 1'b0;
        end else if (accept) begin
            unique case (phase_q)
                PH_A, PH_B: begin
                    asm_d = asm_wr;
                    if (cnt_q == LAST) begin
                        data_d  = asm_wr;
                        cnt_d   = '0;
                        ld_a_d  = (phase_q == PH_A);
                        ld_b_d  = (phase_q == PH_B);
                        phase_d = (phase_q == PH_A) ? PH_B : PH_OP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_OP: begin
                    data_d                = '0;
                    data_d[BYTE_W-1:0]    = byte_in;
                    ld_op_d               = 1'b1;
                    cnt_d                 = '0;
                    phase_d               = PH_A;
                end
                default: begin
                    phase_d = PH_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_A;
            cnt_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            ld_a_q  <= 1'b0;
            ld_b_q  <= 1'b0;
            ld_op_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            ld_a_q  <= ld_a_d;
            ld_b_q  <= ld_b_d;
            ld_op_q <= ld_op_d;
            upd_q   <= upd_d;
        end
    end

    assign data_out  = data_q;
    assign load_A    = ld_a_q;
    assign load_B    = ld_b_q;
    assign load_Op   = ld_op_q;
    assign updateRes = upd_q;
    assign phase     = phase_q;
    assign busy      = (phase_q != PH_A) || (cnt_q != '0);

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small ALU model on its outputs.
`timescale 1ns/1ps
module tb_alu_operand_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  byte_in;
    logic        strobe;
    logic        clear;
    logic [15:0] data_out;
    logic        load_A, load_B, load_Op, updateRes;
    logic [1:0]  phase;
    logic        busy;

    alu_operand_loader #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_in   (byte_in),
        .strobe    (strobe),
        .clear     (clear),
        .data_out  (data_out),
        .load_A    (load_A),
        .load_B    (load_B),
        .load_Op   (load_Op),
        .updateRes (updateRes),
        .phase     (phase),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ALU model and pulse monitor, sampled on the falling edge
    int          n_a = 0, n_b = 0, n_op = 0, n_upd = 0;
    int          seq_err = 0, ovl_err = 0;
    int          exp_next = 0;
    logic [15:0] cap_a = '0, cap_b = '0, cap_op = '0;
    logic [15:0] res_log[$];

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            exp_next = 0;
        end else begin
            if ((int'(load_A === 1'b1) + int'(load_B === 1'b1) + int'(load_Op === 1'b1)) > 1)
                ovl_err++;
            if (updateRes === 1'b1 && (load_A === 1'b1 || load_B === 1'b1 || load_Op === 1'b1))
                ovl_err++;
            if (load_A === 1'b1) begin
                if (exp_next != 0) seq_err++;
                cap_a = data_out; n_a++; exp_next = 1;
            end
            if (load_B === 1'b1) begin
                if (exp_next != 1) seq_err++;
                cap_b = data_out; n_b++; exp_next = 2;
            end
            if (load_Op === 1'b1) begin
                if (exp_next != 2) seq_err++;
                cap_op = data_out; n_op++; exp_next = 3;
            end
            if (updateRes === 1'b1) begin
                if (exp_next != 3) seq_err++;
                case (cap_op[1:0])
                    2'd2:    res_log.push_back(cap_a + cap_b);
                    2'd3:    res_log.push_back(cap_a - cap_b);
                    default: res_log.push_back(16'h0000);
                endcase
                n_upd++; exp_next = 0;
            end
            if (clear === 1'b1) exp_next = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        strobe  = 1'b1;
        step(2);
        strobe  = 1'b0;
        step(2);
    endtask

    typedef struct {
        string       name;
        logic [39:0] bytes;   // byte 0 in the low lane
        logic [15:0] ea, eb, eop, eres;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int upd0;
        upd0 = n_upd;
        for (int k = 0; k < 5; k++) send_byte(v.bytes[8*k +: 8]);
        step(6);
        check({v.name, ".A"},    32'(cap_a),  32'(v.ea));
        check({v.name, ".B"},    32'(cap_b),  32'(v.eb));
        check({v.name, ".OP"},   32'(cap_op), 32'(v.eop));
        check({v.name, ".upd"},  32'(n_upd - upd0), 32'd1);
        check({v.name, ".res"},  32'(res_log[$]), 32'(v.eres));
        check({v.name, ".hold"}, 32'(data_out), 32'(v.eop));
        check({v.name, ".idle"}, {30'd0, phase, busy}, 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int a0, b0, op0, upd0, nl;

        vecs[0] = '{"basic", {8'h02, 8'h00, 8'h01, 8'h12, 8'h34}, 16'h1234, 16'h0001, 16'h0002, 16'h1235};
        vecs[1] = '{"opmask", {8'hFE, 8'h00, 8'h01, 8'h10, 8'h00}, 16'h1000, 16'h0001, 16'h00FE, 16'h1001};
        vecs[2] = '{"wrap", {8'h02, 8'h00, 8'h01, 8'hFF, 8'hFF}, 16'hFFFF, 16'h0001, 16'h0002, 16'h0000};
        vecs[3] = '{"sub", {8'h03, 8'h00, 8'h03, 8'h00, 8'h05}, 16'h0005, 16'h0003, 16'h0003, 16'h0002};

        rst_n = 1'b0; strobe = 1'b0; clear = 1'b0; byte_in = 8'h00;
        step(3);
        check("reset.data_out", 32'(data_out), 32'd0);
        check("reset.pulses", {28'd0, load_A, load_B, load_Op, updateRes}, 32'd0);
        check("reset.phase_busy", {29'd0, phase, busy}, 32'd0);
        rst_n = 1'b1;
        step(2);

        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // reset in the middle of a frame
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h11);
        b0 = n_b;
        rst_n = 1'b0;
        step(1);
        check("rstmid.data_out", 32'(data_out), 32'd0);
        check("rstmid.pulses", {28'd0, load_A, load_B, load_Op, updateRes}, 32'd0);
        check("rstmid.phase_busy", {29'd0, phase, busy}, 32'd0);
        rst_n = 1'b1;
        step(4);
        check("rstmid.no_loadB", 32'(n_b - b0), 32'd0);
        run_vec(vecs[3]);

        // strobe held high yields a single byte
        a0 = n_a;
        byte_in = 8'hAA;
        strobe  = 1'b1;
        step(20);
        check("held.cnt", 32'(dut.cnt_q), 32'd1);
        check("held.busy", 32'(busy), 32'd1);
        check("held.phase", 32'(phase), 32'd0);
        check("held.no_load", 32'(n_a - a0), 32'd0);
        strobe = 1'b0;
        step(2);
        send_byte(8'hBB);
        step(2);
        check("held.loadA_cnt", 32'(n_a - a0), 32'd1);
        check("held.A", 32'(cap_a), 32'h0000BBAA);
        check("held.phase_B", 32'(phase), 32'd1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(2);
        check("held.cleared", {29'd0, phase, busy}, 32'd0);

        // clear landing on the OP byte accept
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        op0  = n_op;
        upd0 = n_upd;
        byte_in = 8'h02;
        strobe  = 1'b1;
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(1);
        strobe = 1'b0;
        step(5);
        check("clr.no_loadOp", 32'(n_op - op0), 32'd0);
        check("clr.no_upd", 32'(n_upd - upd0), 32'd0);
        check("clr.phase_busy", {29'd0, phase, busy}, 32'd0);
        check("clr.data_kept", 32'(data_out), 32'h0002);

        // two frames back to back, strobe every 4 cycles
        upd0 = n_upd;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        step(6);
        nl = res_log.size();
        check("b2b.upd", 32'(n_upd - upd0), 32'd2);
        if (nl >= 2) begin
            check("b2b.res1", 32'(res_log[nl-2]), 32'h0003);
            check("b2b.res2", 32'(res_log[nl-1]), 32'h000F);
        end else begin
            check("b2b.res_count", 32'(nl), 32'd2);
        end
        check("order", 32'(seq_err), 32'd0);
        check("overlap", 32'(ovl_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
